mod_2011_residue_accumulator: RTL and testbench
===============================================

# mod_2011_residue_accumulator

Sequential sink for the chunk-residue stream of the mod-2011 modular-multiplication datapath. The 6-bit-input LUT stages map each operand chunk to an 11-bit residue word. This block consumes those words one per cycle over a valid/ready handshake and folds them into a single residue modulo 2011. After NUM_CHUNKS words it presents the fully reduced result (0..2010) on a valid/ready output port.

## Interface
- NUM_CHUNKS, 4, number of residue words summed per result; legal range 1..255
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream word valid
- in_data  input  11  residue word; any value 0..2047 is legal (values ≥2011 are reduced)
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  result valid
- out_data  output  11  accumulated residue, always 0..2010 when out_valid=1
- out_ready  input  1  downstream accepts result
- busy  output  1  high when at least one word of the current result has been accepted, or a result is pending

## Operation
- Modulus is fixed at M=2011; data width is fixed at 11 bits.
- State: acc[10:0] (invariant acc ≤ 2010), cnt (ceil(log2(NUM_CHUNKS+1)) bits), FSM state ∈ {ACC, OUT}.
- ACC: in_ready=1, out_valid=0. On in_valid & in_ready:
  - s = acc + in_data, 12-bit, max 2010+2047=4057.
  - If s ≥ 4022, acc ← s−4022; else if s ≥ 2011, acc ← s−2011; else acc ← s.
  - cnt ← cnt+1. If cnt = NUM_CHUNKS−1 before the increment, go to OUT.
- OUT: in_ready=0, out_valid=1, out_data=acc, held stable. On out_valid & out_ready: acc←0, cnt←0, go to ACC.
- busy = (state==OUT) | (cnt≠0).
- in_valid is ignored when in_ready=0; no word is lost or double-counted. Upstream holds in_data while in_valid=1 and in_ready=0.
- No combinational path from out_ready to in_ready. The block never accepts an input word in the same cycle a result is consumed.

## Timing
- Reset (rst_n=0 at a rising edge): state=ACC, acc=0, cnt=0. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0. Reset overrides every other event in the same cycle.
- Reset mid-accumulation or with a pending result discards the partial sum or result. No output is produced for the discarded data.
- Throughput is one word per cycle in ACC. A result costs NUM_CHUNKS accept cycles plus at least one OUT cycle.
- Latency: the last word is accepted at edge t; out_valid=1 with the final out_data after edge t (visible in cycle t+1).
- The result is handshaken at edge u; in_ready=1 from cycle u+1.
- NUM_CHUNKS=1: every accepted word goes directly to OUT as in_data mod 2011.
- out_ready held low: out_valid and out_data stay constant indefinitely; in_ready stays 0.
- out_ready=1 already in the first OUT cycle: the result is consumed at that edge, so out_valid is high for exactly one cycle.

## Test plan
- Reset, then NUM_CHUNKS=4, words 1280,1280,1280,1280 back-to-back with out_ready=1 -> intermediate acc 1280, 549, 1829, 1098. One cycle of out_valid=1 with out_data=1098, in_ready=0 in that cycle.
- Double-subtract path: NUM_CHUNKS=2, words 2010,2047 -> out_data=35. Max stream: NUM_CHUNKS=4, four words of 2047 -> out_data=144.
- Backpressure: out_ready=0 for 5 cycles after the result appears -> out_data held at the same value and in_ready=0 for all 5 cycles. in_valid=1 during that window changes nothing. Raise out_ready -> one consume, in_ready=1 the next cycle.
- Gapped input: in_valid toggles 1,0,0,1,0,1,1 carrying words 5,x,x,7,x,11,13 (NUM_CHUNKS=4) -> out_data=36. Only valid cycles are counted.
- Reset mid-operation: accept 100,200, then rst_n=0 for one cycle, then four words of 1 -> out_data=4, busy=0 directly after reset.
- NUM_CHUNKS=1, words 2011, 2047, 0 each consumed immediately -> results 0, 36, 0 in order. busy goes high only in the OUT cycles.

Source files
------------

// File: rtl/mod_2011_residue_accumulator_if.sv
// Handshake bundle for the mod-2011 residue accumulator.
//
// Input side (residue word stream, upstream -> accumulator):
//   in_valid  : upstream word valid
//   in_data   : 11-bit residue word, 0..2047
//   in_ready  : accumulator accepts in_data this cycle
// Output side (reduced result, accumulator -> downstream):
//   out_valid : result valid
//   out_data  : accumulated residue, 0..2010 while out_valid=1
//   out_ready : downstream accepts the result
//
// master : the side that drives the word stream and consumes results
// slave  : the accumulator itself
interface mod_2011_residue_accumulator_if;
    logic        in_valid;
    logic [10:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mod_2011_residue_accumulator.sv
// Sequential sink for the chunk-residue stream of the mod-2011 modular
// multiplication datapath. Accepts one 11-bit residue word per cycle,
// folds it into a running residue modulo 2011, and after NUM_CHUNKS words
// presents the fully reduced result (0..2010) until it is consumed.
//
// Parameters:
//   NUM_CHUNKS : words summed per result, 1..255
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : handshake bundle (slave side), see the interface file
//   busy   : a partial sum is in progress or a result is pending
module mod_2011_residue_accumulator #(
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    mod_2011_residue_accumulator_if.slave       bus,
    output logic                                busy
);

    localparam int unsigned CW = $clog2(NUM_CHUNKS + 1);
    localparam logic [11:0] MOD1 = 12'd2011;
    localparam logic [11:0] MOD2 = 12'd4022;
    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    if (NUM_CHUNKS < 1 || NUM_CHUNKS > 255) begin : g_bad_param
        $error("NUM_CHUNKS must be within 1..255");
    end

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [10:0]     acc;
    logic [10:0]     acc_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [11:0]     sum;
    logic [10:0]     folded;

    // acc <= 2010 and in_data <= 2047, so the sum is at most 4057 < 3*2011;
    // at most two subtractions bring it back into 0..2010.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, bus.in_data};
        if (sum >= MOD2) begin
            folded = 11'(sum - MOD2);
        end else if (sum >= MOD1) begin
            folded = 11'(sum - MOD1);
        end else begin
            folded = sum[10:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    // in_ready depends only on state, so out_ready never reaches it
    // combinationally and no word is accepted in the consume cycle.
    always_comb begin
        state_nx      = state;
        acc_nx        = acc;
        cnt_nx        = cnt;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_nx = folded;
                    cnt_nx = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_nx = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = ST_ACC;
                end
            end
            default: begin
                state_nx = ST_ACC;
            end
        endcase
    end

    // acc is frozen while in ST_OUT, which keeps out_data stable.
    assign bus.out_data = acc;
    assign busy         = (state == ST_OUT) || (cnt != '0);

endmodule

// File: tb/tb_mod_2011_residue_accumulator.sv
module tb_mod_2011_residue_accumulator;

    logic clk;
    logic rst_n;

    // index 0: NUM_CHUNKS=4, 1: NUM_CHUNKS=2, 2: NUM_CHUNKS=1
    logic [2:0]  iv;
    logic [10:0] id [3];
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [10:0] od [3];
    logic [2:0]  bsy;

    int nvec;
    int nmis;

    logic [10:0] q0 [$];
    logic [10:0] q1 [$];
    logic [10:0] q2 [$];

    mod_2011_residue_accumulator_if if0 ();
    mod_2011_residue_accumulator_if if1 ();
    mod_2011_residue_accumulator_if if2 ();

    assign if0.in_valid = iv[0];   assign if0.in_data = id[0];   assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];   assign if1.in_data = id[1];   assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2];   assign if2.in_data = id[2];   assign if2.out_ready = ordy[2];
    assign ir[0] = if0.in_ready;   assign ov[0] = if0.out_valid; assign od[0] = if0.out_data;
    assign ir[1] = if1.in_ready;   assign ov[1] = if1.out_valid; assign od[1] = if1.out_data;
    assign ir[2] = if2.in_ready;   assign ov[2] = if2.out_valid; assign od[2] = if2.out_data;

    mod_2011_residue_accumulator #(.NUM_CHUNKS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .busy(bsy[0]));
    mod_2011_residue_accumulator #(.NUM_CHUNKS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(bsy[1]));
    mod_2011_residue_accumulator #(.NUM_CHUNKS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [1:0]       sel;
        logic [3:0][10:0] w;
        logic [10:0]      exp;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    function automatic int nchunks(input int s);
        case (s)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic vec_t mk(input int s, input int a, input int b,
                                input int c, input int d, input int e);
        vec_t v;
        v.sel  = 2'(s);
        v.w[0] = 11'(a);
        v.w[1] = 11'(b);
        v.w[2] = 11'(c);
        v.w[3] = 11'(d);
        v.exp  = 11'(e);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void qpush(input int s, input logic [10:0] v);
        case (s)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [10:0] qpop(input int s);
        case (s)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Scoreboard: every consumed result is compared with the oldest expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rst_n && ov[s] && ordy[s]) begin
                if (qsize(s) == 0) begin
                    chk($sformatf("spurious_out%0d", s), int'(od[s]), -1);
                end else begin
                    chk($sformatf("result%0d", s), int'(od[s]), int'(qpop(s)));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input int s, input int w);
        int t;
        t = 0;
        iv[s] = 1'b1;
        id[s] = 11'(w);
        @(negedge clk);
        while (!ir[s] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir[s]) chk($sformatf("send_timeout%0d", s), 0, 1);
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
    endtask

    task automatic drain(input int s);
        int t;
        t = 0;
        while (qsize(s) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain%0d", s), qsize(s), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec  = 0;
        nmis  = 0;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        for (int s = 0; s < 3; s++) id[s] = '0;

        tbl[0]  = mk(0, 1280, 1280, 1280, 1280, 1098);
        tbl[1]  = mk(1, 2010, 2047, 0, 0, 35);
        tbl[2]  = mk(0, 2047, 2047, 2047, 2047, 144);
        tbl[3]  = mk(2, 2011, 0, 0, 0, 0);
        tbl[4]  = mk(2, 2047, 0, 0, 0, 36);
        tbl[5]  = mk(2, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 2010, 1, 0, 0, 0);
        tbl[8]  = mk(1, 2010, 2010, 0, 0, 2009);
        tbl[9]  = mk(0, 1000, 1000, 10, 5, 4);
        tbl[10] = mk(2, 2010, 0, 0, 0, 2010);
        tbl[11] = mk(0, 500, 600, 700, 211, 0);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_in_ready%0d", s), int'(ir[s]), 1);
            chk($sformatf("rst_out_valid%0d", s), int'(ov[s]), 0);
            chk($sformatf("rst_out_data%0d", s), int'(od[s]), 0);
            chk($sformatf("rst_busy%0d", s), int'(bsy[s]), 0);
        end
        @(posedge clk);
        #1;

        // Table-driven results, immediate consume
        ordy = '1;
        for (int i = 0; i < NV; i++) begin
            int s;
            s = int'(tbl[i].sel);
            qpush(s, tbl[i].exp);
            for (int k = 0; k < nchunks(s); k++) send(s, int'(tbl[i].w[k]));
            drain(s);
        end

        // Latency and single-cycle out_valid with out_ready already high
        qpush(0, 11'd1098);
        for (int k = 0; k < 4; k++) send(0, 1280);
        @(negedge clk);
        chk("lat_out_valid", int'(ov[0]), 1);
        chk("lat_out_data", int'(od[0]), 1098);
        chk("lat_in_ready", int'(ir[0]), 0);
        chk("lat_busy", int'(bsy[0]), 1);
        @(negedge clk);
        chk("one_cycle_out_valid", int'(ov[0]), 0);
        chk("one_cycle_in_ready", int'(ir[0]), 1);
        chk("one_cycle_busy", int'(bsy[0]), 0);
        drain(0);

        // Backpressure: result held, in_valid ignored
        ordy[0] = 1'b0;
        qpush(0, 11'd144);
        for (int k = 0; k < 4; k++) send(0, 2047);
        iv[0] = 1'b1;
        id[0] = 11'd999;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(ov[0]), 1);
            chk("bp_out_data", int'(od[0]), 144);
            chk("bp_in_ready", int'(ir[0]), 0);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(ir[0]), 1);
        chk("bp_release_out_valid", int'(ov[0]), 0);
        chk("bp_queue", qsize(0), 0);
        @(posedge clk);
        #1;
        qpush(0, 11'd4);
        for (int k = 0; k < 4; k++) send(0, 1);
        drain(0);

        // Gapped input: only valid cycles count
        begin
            logic [6:0] vpat;
            int         wpat [7];
            vpat = 7'b1101001;
            wpat = '{5, 2000, 2000, 7, 2000, 11, 13};
            qpush(0, 11'd36);
            for (int k = 0; k < 7; k++) begin
                iv[0] = vpat[k];
                id[0] = 11'(wpat[k]);
                @(posedge clk);
                #1;
            end
            iv[0] = 1'b0;
            @(negedge clk);
            chk("gap_out_valid", int'(ov[0]), 1);
            chk("gap_out_data", int'(od[0]), 36);
            drain(0);
        end

        // Reset mid-accumulation discards the partial sum
        send(0, 100);
        send(0, 200);
        @(negedge clk);
        chk("mid_busy", int'(bsy[0]), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(bsy[0]), 0);
        chk("post_rst_in_ready", int'(ir[0]), 1);
        chk("post_rst_out_valid", int'(ov[0]), 0);
        @(posedge clk);
        #1;
        qpush(0, 11'd4);
        for (int k = 0; k < 4; k++) send(0, 1);
        drain(0);

        // NUM_CHUNKS=1: busy only in the OUT cycle
        @(negedge clk);
        chk("n1_idle_busy", int'(bsy[2]), 0);
        @(posedge clk);
        #1;
        qpush(2, 11'd0);
        send(2, 2011);
        @(negedge clk);
        chk("n1_out_busy", int'(bsy[2]), 1);
        chk("n1_out_valid", int'(ov[2]), 1);
        @(negedge clk);
        chk("n1_after_busy", int'(bsy[2]), 0);
        drain(2);

        for (int s = 0; s < 3; s++) chk($sformatf("final_queue%0d", s), qsize(s), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
